// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: IMMSRC codes, opcodes, NOP, payloads.
package instr_encoder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMMSRC_W  = 3;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned ERR_CNT_W = 8;

  // Immediate format selector shared with the decoder side.
  typedef enum logic [IMMSRC_W-1:0] {
    IMMSRC_I = 3'd0,
    IMMSRC_S = 3'd1,
    IMMSRC_B = 3'd2,
    IMMSRC_J = 3'd3,
    IMMSRC_U = 3'd4
  } immsrc_e;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One encoded output word as held in the skid buffer.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic            err;
  } enc_word_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field/immediate packing and immediate legality check.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [IMMSRC_W-1:0] immsrc,
  input  logic [XLEN-1:0]     imm,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [F3_W-1:0]     funct3,
  output logic [XLEN-1:0]     instr_c,
  output logic                err_c
);

  logic signed [XLEN-1:0] imm_s;
  assign imm_s = $signed(imm);

  // Build the word per format; out-of-range values still get the truncated encoding.
  always_comb begin
    instr_c = NOP_INSTR;
    err_c   = 1'b1;
    case (immsrc)
      IMMSRC_I: begin
        instr_c = {imm[11:0], rs1, funct3, rd, opcode};
        err_c   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      IMMSRC_S: begin
        instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err_c   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      IMMSRC_B: begin
        instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err_c   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      end
      IMMSRC_J: begin
        instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err_c   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      end
      IMMSRC_U: begin
        instr_c = {imm[31:12], rd, opcode};
        err_c   = |imm[11:0];
      end
      default: begin
        instr_c = NOP_INSTR;
        err_c   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs request fields, buffers results in a 2-entry skid buffer.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IMMSRC_W-1:0]  s_immsrc,
  input  logic [XLEN-1:0]      s_imm,
  input  logic [OPC_W-1:0]     s_opcode,
  input  logic [REG_W-1:0]     s_rd,
  input  logic [REG_W-1:0]     s_rs1,
  input  logic [REG_W-1:0]     s_rs2,
  input  logic [F3_W-1:0]      s_funct3,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [XLEN-1:0]      m_instr,
  output logic                 m_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  buf_state_e           state_q, state_d;
  enc_word_t            head_q, head_d;
  enc_word_t            tail_q, tail_d;
  logic                 m_valid_q, m_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [XLEN-1:0] pack_instr;
  logic            pack_err;
  enc_word_t       new_word;
  logic            accept;
  logic            drain;

  imm_pack u_imm_pack (
    .immsrc  (s_immsrc),
    .imm     (s_imm),
    .opcode  (s_opcode),
    .rd      (s_rd),
    .rs1     (s_rs1),
    .rs2     (s_rs2),
    .funct3  (s_funct3),
    .instr_c (pack_instr),
    .err_c   (pack_err)
  );

  assign new_word  = '{instr: pack_instr, err: pack_err};
  assign s_ready   = (state_q != BUF_TWO);
  assign accept    = s_valid && s_ready;
  assign drain     = m_valid_q && m_ready;
  assign m_valid   = m_valid_q;
  assign m_instr   = head_q.instr;
  assign m_err     = head_q.err;
  assign err_count = err_cnt_q;

  // Buffer next-state: head is always the presented word, tail holds the skid entry.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          head_d  = new_word;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && drain) begin
          head_d = new_word;
        end else if (accept) begin
          tail_d  = new_word;
          state_d = BUF_TWO;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (drain) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (accept && new_word.err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
    m_valid_d = (state_d != BUF_EMPTY);
  end

  // State and datapath registers; reset discards any buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BUF_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      m_valid_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      m_valid_q <= m_valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_immsrc;
  logic [31:0] s_imm;
  logic [6:0]  s_opcode;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [2:0]  s_funct3;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_instr;
  logic        m_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_immsrc  (s_immsrc),
    .s_imm     (s_imm),
    .s_opcode  (s_opcode),
    .s_rd      (s_rd),
    .s_rs1     (s_rs1),
    .s_rs2     (s_rs2),
    .s_funct3  (s_funct3),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_instr   (m_instr),
    .m_err     (m_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until accepted; push its expected word.
  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [31:0] exp_i, input logic exp_e,
                      output int waited);
    logic acc;
    s_immsrc = src; s_imm = imm; s_opcode = op;
    s_rd = rd; s_rs1 = rs1; s_rs2 = rs2; s_funct3 = f3;
    s_valid = 1'b1;
    waited = -1;
    for (int i = 0; i < 50; i++) begin
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        waited = i + 1;
        break;
      end
    end
    s_valid = 1'b0;
    if (waited < 0) chk("accept_timeout", 33'd0, 33'd1);
    else exp_q.push_back({exp_i, exp_e});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 33'(exp_q.size()), 33'd0);
  endtask

  // Output monitor: scoreboard compare on each transfer, stability check on stall.
  logic        stall_prev = 1'b0;
  logic [32:0] word_prev  = '0;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && m_valid) chk("hold_stable", {m_instr, m_err}, word_prev);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {m_instr, m_err}, 33'd0);
        else chk("word", {m_instr, m_err}, exp_q.pop_front());
      end
      stall_prev = m_valid && !m_ready;
      word_prev  = {m_instr, m_err};
    end
  end

  initial begin
    int w;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    s_immsrc = '0; s_imm = '0; s_opcode = '0; s_rd = '0; s_rs1 = '0; s_rs2 = '0; s_funct3 = '0;
    #1;
    chk("rst_m_valid", 33'(m_valid), 33'd0);
    chk("rst_s_ready", 33'(s_ready), 33'd1);
    chk("rst_m_instr", 33'(m_instr), 33'd0);
    chk("rst_m_err", 33'(m_err), 33'd0);
    chk("rst_err_count", 33'(err_count), 33'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Legal encodings of each format
    m_ready = 1'b1;
    send(IMMSRC_I, 32'd5, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0050_0093, 1'b0, w);
    chk("latency_valid", 33'(m_valid), 33'd1);
    chk("latency_instr", 33'(m_instr), 33'h0_0050_0093);
    send(IMMSRC_S, 32'd8, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'h0020_A423, 1'b0, w);
    send(IMMSRC_B, -32'sd4, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE00_0EE3, 1'b0, w);
    send(IMMSRC_J, 32'd8, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0080_00EF, 1'b0, w);
    send(IMMSRC_U, 32'h1234_5000, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 1'b0, w);
    wait_drain();
    chk("err_count_legal", 33'(err_count), 33'd0);

    // Error cases
    send(IMMSRC_B, 32'd3, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0163, 1'b1, w);
    send(IMMSRC_I, 32'd2048, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0013, 1'b1, w);
    send(IMMSRC_U, 32'h0000_1001, OPC_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_1037, 1'b1, w);
    send(3'd7, 32'd0, OPC_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, w);
    wait_drain();
    chk("err_count_4", 33'(err_count), 33'd4);
    chk("last_instr_nop", 33'(m_instr), 33'h0_0000_0013);

    // Range boundaries
    send(IMMSRC_I, -32'sd2048, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0013, 1'b0, w);
    send(IMMSRC_I, 32'd2047, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 32'h7FF0_0013, 1'b0, w);
    send(IMMSRC_B, 32'd4094, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'h7E00_0FE3, 1'b0, w);
    send(IMMSRC_B, 32'd4096, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0063, 1'b1, w);
    send(IMMSRC_J, -32'sd1048576, OPC_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_006F, 1'b0, w);
    send(IMMSRC_J, 32'd1048576, OPC_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_006F, 1'b1, w);
    send(IMMSRC_U, 32'hFFFF_F000, OPC_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_F037, 1'b0, w);
    wait_drain();
    chk("err_count_6", 33'(err_count), 33'd6);

    // Backpressure fills the skid buffer
    m_ready = 1'b0;
    send(IMMSRC_I, 32'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0093, 1'b0, w);
    chk("bp_ready_one", 33'(s_ready), 33'd1);
    send(IMMSRC_I, 32'd2, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 32'h0020_0113, 1'b0, w);
    chk("bp_ready_two", 33'(s_ready), 33'd0);
    s_immsrc = IMMSRC_I; s_imm = 32'd3; s_opcode = OPC_OP_IMM; s_rd = 5'd3;
    s_rs1 = '0; s_rs2 = '0; s_funct3 = '0; s_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_stall_ready", 33'(s_ready), 33'd0);
    chk("bp_stall_head", {m_valid, m_instr}, {1'b1, 32'h0010_0093});
    m_ready = 1'b1;
    send(IMMSRC_I, 32'd3, OPC_OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0030_0193, 1'b0, w);
    chk("bp_third_wait", 33'(w), 33'd2);
    wait_drain();

    // Reset while the buffer holds two words
    m_ready = 1'b0;
    send(IMMSRC_I, 32'd4096, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, w);
    send(IMMSRC_I, 32'd4096, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, w);
    chk("pre_rst_two", {31'd0, s_ready, m_valid}, 33'd1);
    chk("pre_rst_err_count", 33'(err_count), 33'd8);
    #2; reset = 1'b1; #1;
    chk("mid_rst_m_valid", 33'(m_valid), 33'd0);
    chk("mid_rst_s_ready", 33'(s_ready), 33'd1);
    chk("mid_rst_err_count", 33'(err_count), 33'd0);
    chk("mid_rst_m_instr", {m_instr, m_err}, 33'd0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(IMMSRC_J, 32'd8, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0080_00EF, 1'b0, w);
    chk("post_rst_latency", {m_valid, m_instr}, {1'b1, 32'h0080_00EF});
    wait_drain();

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      send(IMMSRC_U, 32'h0000_1001, OPC_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_1037, 1'b1, w);
    end
    wait_drain();
    chk("err_count_sat", 33'(err_count), 33'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
